// File: rtl/dmux_dispatcher.sv
// Round-robin 1-to-N_OUT word dispatcher with per-channel one-entry holding registers and flush.
// Optional accepted-word counter (DISP_COUNT) is compiled in with DMUX_DISPATCH_COUNT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | accepting words, steering each to the next free channel
// FLUSHING | intake stopped, waiting for every channel to drain
module dmux_dispatcher #(
   parameter int WIDTH = 16,
   parameter int N_OUT = 4,
   parameter int PTR_W = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       IN_DATA,
   input  logic                   IN_VALID,
   output logic                   IN_READY,
   output logic [N_OUT*WIDTH-1:0] OUT_DATA,
   output logic [N_OUT-1:0]       OUT_VALID,
   input  logic [N_OUT-1:0]       OUT_READY,
   input  logic                   FLUSH,
   output logic                   FLUSH_DONE,
   output logic [PTR_W-1:0]       PTR,
   output logic                   BUSY
`ifdef DMUX_DISPATCH_COUNT_EN
   ,
   output logic [15:0]            DISP_COUNT
`endif
);

   typedef enum logic {RUN, FLUSHING} state_t;

   state_t                 state_q, state_d;
   logic                   done_d;
   logic                   accept;
   logic [PTR_W-1:0]       grant;
   logic [PTR_W-1:0]       idx;
   logic                   grant_found;
   logic [N_OUT-1:0]       valid_d;

   assign IN_READY = (state_q == RUN) && !FLUSH && !(&OUT_VALID);
   assign accept   = IN_VALID && IN_READY;
   assign BUSY     = (state_q == FLUSHING);

   // Scan from PTR upward; only channels empty at the start of the cycle are eligible.
   always_comb begin
      grant       = PTR;
      idx         = PTR;
      grant_found = 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
         idx = PTR + PTR_W'(k);
         if (!grant_found && !OUT_VALID[idx]) begin
            grant       = idx;
            grant_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         RUN: begin
            if (FLUSH) begin
               if (OUT_VALID == '0) done_d  = 1'b1;
               else                 state_d = FLUSHING;
            end
         end
         FLUSHING: begin
            if (OUT_VALID == '0) begin
               done_d  = 1'b1;
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      valid_d = OUT_VALID & ~OUT_READY;
      if (accept) valid_d[grant] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= RUN;
         FLUSH_DONE <= 1'b0;
         PTR        <= '0;
         OUT_VALID  <= '0;
      end else begin
         state_q    <= state_d;
         FLUSH_DONE <= done_d;
         OUT_VALID  <= valid_d;
         if (done_d)      PTR <= '0;
         else if (accept) PTR <= grant + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         OUT_DATA <= '0;
      end else if (accept) begin
         OUT_DATA[int'(grant)*WIDTH +: WIDTH] <= IN_DATA;
      end
   end

`ifdef DMUX_DISPATCH_COUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       DISP_COUNT <= '0;
      else if (done_d) DISP_COUNT <= '0;
      else if (accept) DISP_COUNT <= DISP_COUNT + 16'd1;
   end
`endif

endmodule

// File: tb/tb_dmux_dispatcher.sv
// Directed bench for dmux_dispatcher: per-cycle vector table plus reset and counter sequences.
module tb_dmux_dispatcher;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] out_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic        flush;
   logic        flush_done;
   logic [1:0]  ptr;
   logic        busy;
`ifdef DMUX_DISPATCH_COUNT_EN
   logic [15:0] disp_count;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic        iv;
      logic [15:0] id;
      logic [3:0]  ordy;
      logic        fl;
      logic        e_ir;
      logic [3:0]  e_ov;
      logic [1:0]  e_ptr;
      logic        e_busy;
      logic        e_fd;
      logic        dchk;
      int          dch;
      logic [15:0] e_data;
   } vec_t;

   vec_t vq[$];

   dmux_dispatcher #(.WIDTH(16), .N_OUT(4), .PTR_W(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .IN_DATA    (in_data),
      .IN_VALID   (in_valid),
      .IN_READY   (in_ready),
      .OUT_DATA   (out_data),
      .OUT_VALID  (out_valid),
      .OUT_READY  (out_ready),
      .FLUSH      (flush),
      .FLUSH_DONE (flush_done),
      .PTR        (ptr),
      .BUSY       (busy)
`ifdef DMUX_DISPATCH_COUNT_EN
      ,
      .DISP_COUNT (disp_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic iv, input logic [15:0] id, input logic [3:0] ordy, input logic fl,
                      input logic e_ir, input logic [3:0] e_ov, input logic [1:0] e_ptr,
                      input logic e_busy, input logic e_fd, input logic dchk, input int dch,
                      input logic [15:0] e_data);
      vec_t v;
      v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl; v.e_ir = e_ir; v.e_ov = e_ov;
      v.e_ptr = e_ptr; v.e_busy = e_busy; v.e_fd = e_fd; v.dchk = dchk; v.dch = dch;
      v.e_data = e_data;
      vq.push_back(v);
   endtask

   initial begin
      reset     = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = '0;
      flush     = 1'b0;

      //  iv  data      ordy     fl | ir  ov       ptr  busy fd  dchk ch data
      // round robin, all consumers ready
      add(1, 16'h0011, 4'b1111, 0,  1, 4'b0001, 2'd1, 0, 0,  1, 0, 16'h0011);
      add(1, 16'h0022, 4'b1111, 0,  1, 4'b0010, 2'd2, 0, 0,  1, 1, 16'h0022);
      add(1, 16'h0033, 4'b1111, 0,  1, 4'b0100, 2'd3, 0, 0,  1, 2, 16'h0033);
      add(1, 16'h0044, 4'b1111, 0,  1, 4'b1000, 2'd0, 0, 0,  1, 3, 16'h0044);
      add(1, 16'h0055, 4'b1111, 0,  1, 4'b0001, 2'd1, 0, 0,  1, 0, 16'h0055);
      add(0, 16'h0000, 4'b1111, 0,  1, 4'b0000, 2'd1, 0, 0,  1, 0, 16'h0055);
      // fill all, then free 0/2/3 so PTR=1 points at a full channel
      add(1, 16'hAAAA, 4'b0000, 0,  1, 4'b0010, 2'd2, 0, 0,  1, 1, 16'hAAAA);
      add(1, 16'hBBBB, 4'b0000, 0,  1, 4'b0110, 2'd3, 0, 0,  1, 2, 16'hBBBB);
      add(1, 16'hCCCC, 4'b0000, 0,  1, 4'b1110, 2'd0, 0, 0,  1, 3, 16'hCCCC);
      add(1, 16'hDDDD, 4'b0000, 0,  1, 4'b1111, 2'd1, 0, 0,  1, 0, 16'hDDDD);
      add(1, 16'hEEEE, 4'b0000, 0,  0, 4'b1111, 2'd1, 0, 0,  1, 0, 16'hDDDD);
      add(0, 16'h0000, 4'b1101, 0,  0, 4'b0010, 2'd1, 0, 0,  1, 1, 16'hAAAA);
      add(1, 16'hBEEF, 4'b0000, 0,  1, 4'b0110, 2'd3, 0, 0,  1, 2, 16'hBEEF);
      // drain and accept in one cycle
      add(1, 16'h1234, 4'b0010, 0,  1, 4'b1100, 2'd0, 0, 0,  1, 3, 16'h1234);
      add(1, 16'h5678, 4'b0000, 0,  1, 4'b1101, 2'd1, 0, 0,  1, 0, 16'h5678);
      add(1, 16'h9999, 4'b0000, 0,  1, 4'b1111, 2'd2, 0, 0,  1, 1, 16'h9999);
      // full stall: freed slot usable only next cycle
      add(1, 16'h7777, 4'b0100, 0,  0, 4'b1011, 2'd2, 0, 0,  1, 2, 16'hBEEF);
      add(1, 16'h7777, 4'b0000, 0,  1, 4'b1111, 2'd3, 0, 0,  1, 2, 16'h7777);
      // flush with three channels held
      add(0, 16'h0000, 4'b0001, 0,  0, 4'b1110, 2'd3, 0, 0,  0, 0, 16'h0000);
      add(0, 16'h0000, 4'b0000, 1,  0, 4'b1110, 2'd3, 1, 0,  0, 0, 16'h0000);
      add(1, 16'hAAAA, 4'b0010, 0,  0, 4'b1100, 2'd3, 1, 0,  1, 1, 16'h9999);
      add(1, 16'hAAAA, 4'b0100, 0,  0, 4'b1000, 2'd3, 1, 0,  0, 0, 16'h0000);
      add(1, 16'hAAAA, 4'b1000, 0,  0, 4'b0000, 2'd3, 1, 0,  1, 3, 16'h1234);
      add(1, 16'hAAAA, 4'b0000, 0,  0, 4'b0000, 2'd0, 0, 1,  0, 0, 16'h0000);
      add(0, 16'h0000, 4'b0000, 0,  1, 4'b0000, 2'd0, 0, 0,  0, 0, 16'h0000);
      // flush with nothing held completes without leaving RUN
      add(1, 16'h4242, 4'b0000, 1,  0, 4'b0000, 2'd0, 0, 1,  0, 0, 16'h0000);
      add(1, 16'h4242, 4'b0000, 0,  1, 4'b0001, 2'd1, 0, 0,  1, 0, 16'h4242);

      #12;
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_out_data",  out_data[31:0] | out_data[63:32], 32'h0);
      chk("reset_ptr",       32'(ptr), 32'h0);
      chk("reset_busy",      32'(busy), 32'h0);
      chk("reset_flush_done", 32'(flush_done), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("reset_in_ready", 32'(in_ready), 32'h1);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         in_valid  = vq[i].iv;
         in_data   = vq[i].id;
         out_ready = vq[i].ordy;
         flush     = vq[i].fl;
         #1 chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vq[i].e_ir));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
         chk($sformatf("v%0d_ptr", i), 32'(ptr), 32'(vq[i].e_ptr));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vq[i].e_busy));
         chk($sformatf("v%0d_flush_done", i), 32'(flush_done), 32'(vq[i].e_fd));
         if (vq[i].dchk)
            chk($sformatf("v%0d_out_data", i), 32'(out_data[vq[i].dch*16 +: 16]), 32'(vq[i].e_data));
      end

      // reset mid-stream: two more words into channels 1 and 2, then async reset between edges
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h0101; out_ready = 4'b0000; flush = 1'b0;
      @(negedge clk);
      in_data = 16'h0202;
      @(posedge clk);
      #1 chk("pre_reset_out_valid", 32'(out_valid), 32'h7);
      chk("pre_reset_ptr", 32'(ptr), 32'h3);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("async_reset_out_valid", 32'(out_valid), 32'h0);
      chk("async_reset_ptr", 32'(ptr), 32'h0);
      chk("async_reset_out_data", out_data[31:0] | out_data[63:32], 32'h0);
      #1 reset = 1'b0;
      #1 chk("post_reset_in_ready", 32'(in_ready), 32'h1);

`ifdef DMUX_DISPATCH_COUNT_EN
      chk("count_after_reset", 32'(disp_count), 32'h0);
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h5A5A; out_ready = 4'b1111;
      repeat (65537) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("count_wrap", 32'(disp_count), 32'h1);
      @(negedge clk);
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b1;
      @(negedge clk);
      flush     = 1'b0;
      out_ready = 4'b1111;
      begin
         bit seen = 1'b0;
         for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #1 if (flush_done) seen = 1'b1;
         end
         chk("count_flush_done_seen", 32'(seen), 32'h1);
      end
      chk("count_after_flush", 32'(disp_count), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
